mul2vector_feeder: RTL

Upstream operand sequencer for the 2-element dot-product multiplier (C = A0*B0 + A1*B1, 9-bit result).
- Accepts a serial stream of unsigned DW-bit elements: a ROWSx2 matrix A in row-major order, followed by a 2-element column vector B.
- Buffers the stream, then issues one matrix row at a time together with B under a valid/ready handshake.
- The downstream multiplier therefore produces the matrix-vector product one row per accepted transfer.

---
 rtl/mul2vector_feeder.sv | 115 +++++++++++
 1 files changed

// File: rtl/mul2vector_feeder.sv
// Operand sequencer for a 2-element dot-product multiplier: buffers a ROWSx2 matrix
// plus a 2-element vector from a serial stream, then issues one row at a time with B.
module mul2vector_feeder #(
    parameter int DW   = 4,
    parameter int ROWS = 2,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW  = $clog2(2 * ROWS + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] A0,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] B0,
    output logic [DW-1:0] B1,
    output logic [RW-1:0] op_row,
    output logic          op_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE
    } state_t;

    localparam logic [CW-1:0] IDX_B0   = CW'(2 * ROWS);
    localparam logic [CW-1:0] IDX_B1   = CW'(2 * ROWS + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] b0_q;
    logic [DW-1:0] a0_mem [ROWS];
    logic [DW-1:0] a1_mem [ROWS];
    logic [RW-1:0] row_nxt;

    assign row_nxt = op_row + 1'b1;

    // Matrix elements are split by column so a row is fetched with the row index directly;
    // b1 is the final element and goes straight to the B1 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            op_valid <= 1'b0;
            A0       <= '0;
            A1       <= '0;
            B0       <= '0;
            B1       <= '0;
            op_row   <= '0;
            op_last  <= 1'b0;
            cnt      <= '0;
            b0_q     <= '0;
            for (int i = 0; i < ROWS; i++) begin
                a0_mem[i] <= '0;
                a1_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_LOAD;
                    in_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (cnt == IDX_B1) begin
                            cnt      <= '0;
                            op_row   <= '0;
                            in_ready <= 1'b0;
                            op_valid <= 1'b1;
                            A0       <= a0_mem[0];
                            A1       <= a1_mem[0];
                            B0       <= b0_q;
                            B1       <= in_data;
                            op_last  <= (ROW_LAST == '0);
                            state    <= S_ISSUE;
                        end else begin
                            if (cnt == IDX_B0) begin
                                b0_q <= in_data;
                            end else if (cnt[0]) begin
                                a1_mem[cnt[RW:1]] <= in_data;
                            end else begin
                                a0_mem[cnt[RW:1]] <= in_data;
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_valid && op_ready) begin
                        if (op_row == ROW_LAST) begin
                            op_valid <= 1'b0;
                            op_last  <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            op_row  <= row_nxt;
                            A0      <= a0_mem[row_nxt];
                            A1      <= a1_mem[row_nxt];
                            op_last <= (row_nxt == ROW_LAST);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
